cnt12_sched: RTL and testbench



---
 rtl/cnt12_pkg.sv | 37 +++
 rtl/cnt12_sched_if.sv | 34 +++
 rtl/cnt12_step.sv | 32 +++
 rtl/cnt12_sched.sv | 162 ++++++++++++++++
 tb/tb_cnt12_sched.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cnt12_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnt12_pkg
// Description : Shared types, constants and mod-12 helper for the cnt12
//               position scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package cnt12_pkg;

    localparam logic [3:0] CNT12_MAX  = 4'd11;
    localparam logic [3:0] CNT12_HALF = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    // Forward (upward) distance from pos to target around the 12-position ring.
    // Both operands are expected in 0..11; a 5-bit sum keeps target+12 exact.
    function automatic logic [3:0] mod12_diff(input logic [3:0] target,
                                              input logic [3:0] pos);
        logic [4:0] sum;
        sum = {1'b0, target} + 5'd12 - {1'b0, pos};
        if (sum >= 5'd12) begin
            sum = sum - 5'd12;
        end
        return sum[3:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/cnt12_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : cnt12_sched_if
// Description : Request handshakes and status outputs of the cnt12 position
//               scheduler. master = requester/observer side, slave = scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface cnt12_sched_if;

    logic       req_a_valid;
    logic [3:0] req_a_target;
    logic       req_a_ready;
    logic       req_b_valid;
    logic [3:0] req_b_target;
    logic       req_b_ready;
    logic [3:0] pos;
    logic       busy;
    logic       dir_up;
    logic       done_a;
    logic       done_b;
    logic       err;

    modport master (
        output req_a_valid, req_a_target, req_b_valid, req_b_target,
        input  req_a_ready, req_b_ready, pos, busy, dir_up, done_a, done_b, err
    );

    modport slave (
        input  req_a_valid, req_a_target, req_b_valid, req_b_target,
        output req_a_ready, req_b_ready, pos, busy, dir_up, done_a, done_b, err
    );

endinterface
`default_nettype wire

// File: rtl/cnt12_step.sv
`default_nettype none
// ============================================================================
// Module      : cnt12_step
// Description : Mod-12 up/down counter. One step per enabled cycle, ud=1
//               counts up (11 -> 0 wrap), ud=0 counts down (0 -> 11 wrap).
// Revision    : 1.0 - initial release
// ============================================================================
module cnt12_step
    import cnt12_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       enable,
    input  wire logic       ud,
    output logic [3:0]      q
);

    // Single-step position update with wrap at both ends of the ring.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 4'd0;
        end else if (enable) begin
            if (ud) begin
                q <= (q >= CNT12_MAX) ? 4'd0 : q + 4'd1;
            end else begin
                q <= ((q == 4'd0) || (q > CNT12_MAX)) ? CNT12_MAX : q - 4'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cnt12_sched.sv
`default_nettype none
// ============================================================================
// Module      : cnt12_sched
// Description : Round-robin position scheduler for a shared mod-12 counter.
//               Grants one of two requesters, moves the counter along the
//               shortest wrap-around path at one step per STEP_DIV cycles,
//               and pulses done to the winner.
// Options     : CNT12_SCHED_TARGET_CHECK_EN - reject targets above 11 (no
//               motion, err pulses with done) instead of clamping them to 11.
// Revision    : 1.0 - initial release
// ============================================================================
module cnt12_sched
    import cnt12_pkg::*;
#(
    parameter int STEP_DIV = 4,
    parameter int PDIV_W   = 8
)(
    input  wire logic   clk,
    input  wire logic   reset,
    cnt12_sched_if.slave bus
);

    localparam logic [PDIV_W-1:0] PRESC_LAST = PDIV_W'(STEP_DIV - 1);

    sched_state_t      state;
    req_id_t           last_grant;
    req_id_t           cur_id;
    logic [3:0]        target;
    logic              bad_target;
    logic [PDIV_W-1:0] presc;
    logic              busy_r;
    logic              dir_r;
    logic              done_a_r;
    logic              done_b_r;
    logic              err_r;

    logic [3:0]        pos;
    logic              grant_a;
    logic              grant_b;
    logic              accept;
    req_id_t           grant_id;
    logic [3:0]        req_target;
    logic              req_bad;
    logic              accept_bad;
    logic [3:0]        eff_target;
    logic [3:0]        fwd;
    logic              at_target;
    logic              step_en;

    // Round-robin grant: on contention the requester not served last wins.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state == IDLE) begin
            if (bus.req_a_valid && bus.req_b_valid) begin
                grant_a = (last_grant == REQ_B);
                grant_b = (last_grant == REQ_A);
            end else begin
                grant_a = bus.req_a_valid;
                grant_b = bus.req_b_valid;
            end
        end
    end

    // A grant is only ever given to a valid requester, so grant == transfer.
    assign accept     = grant_a | grant_b;
    assign grant_id   = grant_b ? REQ_B : REQ_A;
    assign req_target = grant_b ? bus.req_b_target : bus.req_a_target;
    assign req_bad    = (req_target > CNT12_MAX);
    assign eff_target = req_bad ? CNT12_MAX : req_target;
    assign fwd        = mod12_diff(eff_target, pos);

`ifdef CNT12_SCHED_TARGET_CHECK_EN
    assign accept_bad = req_bad;
`else
    assign accept_bad = 1'b0;
`endif

    assign at_target = (pos == target);
    assign step_en   = (state == MOVE) && !at_target && !bad_target &&
                       (presc == PRESC_LAST);

    // Scheduler FSM: arbitration, move pacing and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= REQ_B;
            cur_id     <= REQ_A;
            target     <= 4'd0;
            bad_target <= 1'b0;
            presc      <= '0;
            busy_r     <= 1'b0;
            dir_r      <= 1'b1;
            done_a_r   <= 1'b0;
            done_b_r   <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            done_a_r <= 1'b0;
            done_b_r <= 1'b0;
            err_r    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        target     <= eff_target;
                        bad_target <= accept_bad;
                        cur_id     <= grant_id;
                        last_grant <= grant_id;
                        presc      <= '0;
                        busy_r     <= 1'b1;
                        // Zero distance (or a rejected target) keeps the old direction.
                        if ((fwd != 4'd0) && !accept_bad) begin
                            dir_r <= (fwd <= CNT12_HALF);
                        end
                        state <= MOVE;
                    end
                end
                MOVE: begin
                    if (at_target || bad_target) begin
                        done_a_r <= (cur_id == REQ_A);
                        done_b_r <= (cur_id == REQ_B);
                        err_r    <= bad_target;
                        state    <= DONE;
                    end else if (presc == PRESC_LAST) begin
                        presc <= '0;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                DONE: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    cnt12_step u_step (
        .clk    (clk),
        .reset  (reset),
        .enable (step_en),
        .ud     (dir_r),
        .q      (pos)
    );

    assign bus.req_a_ready = grant_a;
    assign bus.req_b_ready = grant_b;
    assign bus.pos         = pos;
    assign bus.busy        = busy_r;
    assign bus.dir_up      = dir_r;
    assign bus.done_a      = done_a_r;
    assign bus.done_b      = done_b_r;
`ifdef CNT12_SCHED_TARGET_CHECK_EN
    assign bus.err         = err_r;
`else
    assign bus.err         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cnt12_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnt12_sched
// Description : Self-checking bench for cnt12_sched. Two instances: one with
//               STEP_DIV=1, one with STEP_DIV=4; a select bit routes stimulus
//               and observation to one of them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnt12_sched;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cnt12_sched_if bus1 ();
    cnt12_sched_if bus4 ();

    cnt12_sched #(.STEP_DIV(1), .PDIV_W(8)) u_fast (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    cnt12_sched #(.STEP_DIV(4), .PDIV_W(8)) u_slow (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    logic       sel;
    logic       va, vb;
    logic [3:0] ta, tb;

    assign bus1.req_a_valid  = va & ~sel;
    assign bus1.req_b_valid  = vb & ~sel;
    assign bus4.req_a_valid  = va & sel;
    assign bus4.req_b_valid  = vb & sel;
    assign bus1.req_a_target = ta;
    assign bus1.req_b_target = tb;
    assign bus4.req_a_target = ta;
    assign bus4.req_b_target = tb;

    logic       ra, rb, busy, dir, da, db, er;
    logic [3:0] pos;
    assign ra   = sel ? bus4.req_a_ready : bus1.req_a_ready;
    assign rb   = sel ? bus4.req_b_ready : bus1.req_b_ready;
    assign pos  = sel ? bus4.pos         : bus1.pos;
    assign busy = sel ? bus4.busy        : bus1.busy;
    assign dir  = sel ? bus4.dir_up      : bus1.dir_up;
    assign da   = sel ? bus4.done_a      : bus1.done_a;
    assign db   = sel ? bus4.done_b      : bus1.done_b;
    assign er   = sel ? bus4.err         : bus1.err;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: position, last winner (0=A, 1=B), direction.
    int m_pos, m_last, m_dir, sd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; va = 1'b0; vb = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_pos = 0; m_last = 1; m_dir = 1;
        sd = sel ? 4 : 1;
        @(negedge clk);
        chk("rst_pos", pos, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dir", dir, 1);
        chk("rst_done_a", da, 0);
        chk("rst_done_b", db, 0);
        chk("rst_err", er, 0);
        chk("rst_ready", {ra, rb}, 0);
        @(posedge clk); #1;
    endtask

    // Serve one or two requests to completion, checking every cycle against
    // the model. Called and returns at posedge+1.
    task automatic serve(input logic wa, input logic wb,
                         input logic [3:0] tga, input logic [3:0] tgb,
                         output int first_b, output int fin_pos, output int fin_dir);
        logic pa, pb;
        int gid, tgt, fwd, d, lat, step, start, n, npos, bad;
        pa = wa; pb = wb;
        first_b = -1; fin_pos = -1; fin_dir = -1;
        va = pa; vb = pb; ta = tga; tb = tgb;
        while (pa || pb) begin
            if (pa && pb) gid = (m_last == 1) ? 0 : 1;
            else          gid = pa ? 0 : 1;
            tgt = (gid == 0) ? int'(tga) : int'(tgb);
            bad = 0;
            if (tgt > 11) begin
`ifdef CNT12_SCHED_TARGET_CHECK_EN
                bad = 1;
`endif
                tgt = 11;
            end
            fwd  = (tgt - m_pos + 12) % 12;
            d    = (fwd <= 6) ? fwd : 12 - fwd;
            step = (fwd <= 6) ? 1 : -1;
            if (bad != 0)      d = 0;
            else if (fwd != 0) m_dir = (fwd <= 6) ? 1 : 0;
            lat   = d * sd + 2;
            start = m_pos;
            @(negedge clk);
            chk("ready_a", ra, (gid == 0));
            chk("ready_b", rb, (gid == 1));
            chk("busy_idle", busy, 0);
            if (first_b < 0) first_b = int'(rb);
            @(posedge clk); #1;
            if (gid == 0) begin pa = 1'b0; va = 1'b0; end
            else          begin pb = 1'b0; vb = 1'b0; end
            m_last = gid;
            for (int c = 1; c <= lat; c++) begin
                n = (c - 1) / sd;
                if (n > d) n = d;
                npos = ((start + step * n) % 12 + 12) % 12;
                @(negedge clk);
                chk("pos", pos, npos);
                chk("busy", busy, 1);
                chk("done_a", da, (c == lat) && (gid == 0));
                chk("done_b", db, (c == lat) && (gid == 1));
                chk("err", er, (c == lat) && (bad != 0));
                if (c == lat) begin
                    chk("dir_up", dir, m_dir);
                    fin_pos = int'(pos);
                    fin_dir = int'(dir);
                end
                @(posedge clk); #1;
            end
            m_pos = ((start + step * d) % 12 + 12) % 12;
        end
    endtask

    task automatic rand_phase(input int count);
        int r, fb, fp, fd;
        logic wa, wb;
        logic [3:0] xa, xb;
        for (int i = 0; i < count; i++) begin
            r  = int'($urandom_range(0, 2));
            wa = (r != 1);
            wb = (r != 0);
            xa = 4'($urandom_range(0, 13));
            xb = 4'($urandom_range(0, 13));
            serve(wa, wb, xa, xb, fb, fp, fd);
        end
    endtask

    typedef struct {
        logic       wa;
        logic       wb;
        logic [3:0] ta;
        logic [3:0] tb;
        int         first_b;
        int         pos;
        int         dir;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fb, fp, fd, seen_da, done_cyc, endpos;
        reset = 1'b1; va = 1'b0; vb = 1'b0; ta = 4'd0; tb = 4'd0; sel = 1'b0;

        // Expected values hand-derived, starting from pos 0 after reset.
        tbl[0]  = '{1'b1, 1'b0, 4'd3,  4'd0,  0, 3,  1}; // up 0->3
        tbl[1]  = '{1'b1, 1'b0, 4'd1,  4'd0,  0, 1,  0}; // down 3->1
        tbl[2]  = '{1'b1, 1'b0, 4'd10, 4'd0,  0, 10, 0}; // down across 0->11
        tbl[3]  = '{1'b1, 1'b0, 4'd0,  4'd0,  0, 0,  1}; // up across 11->0
        tbl[4]  = '{1'b1, 1'b0, 4'd6,  4'd0,  0, 6,  1}; // tie at 6 goes up
        tbl[5]  = '{1'b0, 1'b1, 4'd0,  4'd5,  1, 5,  0}; // B alone
        tbl[6]  = '{1'b1, 1'b1, 4'd2,  4'd9,  0, 9,  0}; // pair, A first
        tbl[7]  = '{1'b1, 1'b0, 4'd5,  4'd0,  0, 5,  0}; // A alone
        tbl[8]  = '{1'b1, 1'b1, 4'd7,  4'd0,  1, 7,  0}; // pair, B first
        tbl[9]  = '{1'b1, 1'b0, 4'd7,  4'd0,  0, 7,  0}; // already there
`ifdef CNT12_SCHED_TARGET_CHECK_EN
        tbl[10] = '{1'b1, 1'b0, 4'd14, 4'd0,  0, 7,  0}; // rejected, no motion
`else
        tbl[10] = '{1'b1, 1'b0, 4'd14, 4'd0,  0, 11, 1}; // clamped to 11
`endif
        tbl[11] = '{1'b0, 1'b1, 4'd0,  4'd11, 1, 11, 1};

        // STEP_DIV=1 instance: table, then random traffic.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            serve(tbl[i].wa, tbl[i].wb, tbl[i].ta, tbl[i].tb, fb, fp, fd);
            chk($sformatf("tbl%0d_first_b", i), fb, tbl[i].first_b);
            chk($sformatf("tbl%0d_pos", i), fp, tbl[i].pos);
            chk($sformatf("tbl%0d_dir", i), fd, tbl[i].dir);
        end
        rand_phase(60);

        // STEP_DIV=4 instance: reset in the middle of a move.
        sel = 1'b1;
        do_reset();
        va = 1'b1; ta = 4'd8;
        @(negedge clk);
        chk("mid_ready_a", ra, 1);
        @(posedge clk); #1;
        va = 1'b0;
        seen_da = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (da) seen_da = 1;
            @(posedge clk); #1;
        end
        vb = 1'b1; tb = 4'd5;
        @(negedge clk);
        chk("mid_pos_before_reset", pos, 11);
        chk("mid_ready_b_busy", rb, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_pos_after_reset", pos, 0);
        chk("mid_busy_after_reset", busy, 0);
        chk("mid_pending_b_ready", rb, 1);
        if (da) seen_da = 1;
        @(posedge clk); #1;
        vb = 1'b0;
        done_cyc = -1; endpos = -1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (da) seen_da = 1;
            if (db && done_cyc < 0) done_cyc = c;
            if (c == 22) endpos = int'(pos);
            @(posedge clk); #1;
        end
        chk("mid_no_done_a", seen_da, 0);
        chk("mid_b_done_cycle", done_cyc, 22);
        chk("mid_b_pos", endpos, 5);
        m_pos = 5; m_last = 1; m_dir = 1;

        rand_phase(30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
